pascal_coeff_gen: RTL

- Sequential generator of binomial filter weights: builds row `order` of Pascal's triangle iteratively, one row per clock.
- Sits directly upstream of the binomial filter. It supplies the packed coefficient vector and the normalisation shift (row sum = 2^order).
- The filter latches the coefficients when `coef_valid` is high and applies them to its num_elem-tap window.

---
 rtl/pascal_coeff_gen_if.sv | 26 ++
 rtl/pascal_coeff_gen.sv | 112 +++++++++++
 2 files changed

// File: rtl/pascal_coeff_gen_if.sv
// Request/response bundle between a coefficient consumer (master) and
// pascal_coeff_gen (slave).
interface pascal_coeff_gen_if #(
  parameter int data_width = 8,
  parameter int num_elem   = 3
);
  localparam int OW = ($clog2(num_elem) > 1) ? $clog2(num_elem) : 1;

  logic                           start;
  logic [OW-1:0]                  order;
  logic                           busy;
  logic                           coef_valid;
  logic [num_elem*data_width-1:0] coef_flat;
  logic [OW-1:0]                  norm_shift;
  logic                           ovf;

  modport master (
    output start, order,
    input  busy, coef_valid, coef_flat, norm_shift, ovf
  );

  modport slave (
    input  start, order,
    output busy, coef_valid, coef_flat, norm_shift, ovf
  );
endinterface

// File: rtl/pascal_coeff_gen.sv
// Iterative Pascal's-triangle row builder feeding the binomial filter.
// Define PASCAL_COEF_SAT_EN for saturating adds with a sticky ovf flag.
module pascal_coeff_gen #(
  parameter int data_width = 8,
  parameter int num_elem   = 3
) (
  input  logic              clk,
  input  logic              rst,
  pascal_coeff_gen_if.slave bus
);
  localparam int OW = ($clog2(num_elem) > 1) ? $clog2(num_elem) : 1;
  localparam logic [OW-1:0] MAX_ORD = OW'(num_elem - 1);

  typedef enum logic [1:0] {IDLE, BUILD, HOLD} state_t;

  state_t                                 state_q, state_d;
  logic [num_elem-1:0][data_width-1:0]    coef_q, coef_d;
  logic [OW-1:0]                          shift_q, shift_d;
  logic [OW-1:0]                          cnt_q, cnt_d;
  logic                                   busy_q, busy_d;
  logic                                   valid_q, valid_d;
  logic [OW-1:0]                          ord_eff;
`ifdef PASCAL_COEF_SAT_EN
  logic                                   ovf_q, ovf_d;
  logic [data_width:0]                    sum;
`endif

  assign ord_eff = (bus.order > MAX_ORD) ? MAX_ORD : bus.order;

  // One Pascal row step per BUILD cycle; every tap reads pre-edge values.
  always_comb begin
    state_d = state_q;
    coef_d  = coef_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef PASCAL_COEF_SAT_EN
    ovf_d   = ovf_q;
    sum     = '0;
`endif
    case (state_q)
      IDLE, HOLD: begin
        if (bus.start) begin
          shift_d   = ord_eff;
          coef_d    = '0;
          coef_d[0] = data_width'(1);
          cnt_d     = '0;
`ifdef PASCAL_COEF_SAT_EN
          ovf_d     = 1'b0;
`endif
          state_d   = BUILD;
        end
      end
      BUILD: begin
        if (cnt_q < shift_q) begin
          cnt_d = cnt_q + OW'(1);
          for (int i = 1; i < num_elem; i++) begin
`ifdef PASCAL_COEF_SAT_EN
            sum = {1'b0, coef_q[i]} + {1'b0, coef_q[i-1]};
            if (sum[data_width]) begin
              coef_d[i] = '1;
              ovf_d     = 1'b1;
            end else begin
              coef_d[i] = sum[data_width-1:0];
            end
`else
            coef_d[i] = coef_q[i] + coef_q[i-1];
`endif
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == BUILD);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      coef_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef PASCAL_COEF_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      coef_q  <= coef_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
`ifdef PASCAL_COEF_SAT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.coef_valid = valid_q;
  assign bus.coef_flat  = coef_q;
  assign bus.norm_shift = shift_q;
`ifdef PASCAL_COEF_SAT_EN
  assign bus.ovf        = ovf_q;
`else
  assign bus.ovf        = 1'b0;
`endif
endmodule
